// File: rtl/bin2bcd_dd.sv
// bin2bcd_dd: sequential double-dabble binary-to-BCD converter with sign handling.
// Latency: out_DONE is high in the cycle after the 2*W_BIN-th edge following the accepting edge.
//          The latency does not depend on the input data.
// Backpressure: none. init is accepted only in IDLE and ignored while a conversion is in flight.
//
// Ports:
//   clk, rst      rising-edge clock; asynchronous active-high reset
//   init          start request, sampled only in IDLE
//   in_SIGNED     1 = in_BIN is two's complement; sampled together with init
//   in_BIN        W_BIN-bit value to convert; sampled together with init
//   out_BCD       N_DIG BCD digits, units digit in bits [3:0]
//   out_NEG       sign of the last converted value
//   out_OVF       magnitude did not fit in N_DIG digits (out_BCD holds the low digits)
//   out_BUSY      high while in ADJ or SHIFT
//   out_DONE      one-cycle completion pulse
module bin2bcd_dd #(
  parameter int W_BIN = 9,   // legal range 2..32
  parameter int N_DIG = 3    // legal range 1..10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 in_SIGNED,
  input  logic [W_BIN-1:0]     in_BIN,
  output logic [4*N_DIG-1:0]   out_BCD,
  output logic                 out_NEG,
  output logic                 out_OVF,
  output logic                 out_BUSY,
  output logic                 out_DONE
);

  // The counter must be able to hold W_BIN itself.
  localparam int              CW       = $clog2(W_BIN + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(W_BIN);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [W_BIN-1:0] BIN_ONE = W_BIN'(1);
  localparam int              DW       = 4 * N_DIG;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADJ   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Working state
  logic [W_BIN-1:0] mag_q, mag_d;   // magnitude being shifted out MSB first
  logic [DW-1:0]    dig_q, dig_d;   // BCD digits being built up
  logic [CW-1:0]    cnt_q, cnt_d;   // completed shift steps
  logic             ovf_q, ovf_d;   // sticky: a 1 has left the top digit
  logic             neg_q, neg_d;   // captured sign

  // Registered outputs
  logic [DW-1:0]    bcd_q, bcd_d;
  logic             oneg_q, oneg_d;
  logic             oovf_q, oovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Input decode: sign and magnitude. Negation is done as W_BIN-bit unsigned,
  // so the most negative value yields 2^(W_BIN-1) without needing an extra bit.
  logic             in_neg;
  logic [W_BIN-1:0] in_mag;

  always_comb begin
    in_neg = in_SIGNED & in_BIN[W_BIN-1];
    in_mag = in_neg ? (~in_BIN + BIN_ONE) : in_BIN;
  end

  // Adjust step: every digit >= 5 gets +3 so that the following shift
  // produces a correct decimal carry into the next digit. All digits in parallel.
  logic [DW-1:0] dig_adj;

  always_comb begin
    dig_adj = dig_q;
    for (int k = 0; k < N_DIG; k++) begin
      if (dig_q[4*k +: 4] >= 4'd5) begin
        dig_adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Shift step: the digits and the magnitude move left as one register.
  // The bit leaving the top digit is the decimal carry out of the kept digits.
  logic [DW+W_BIN-1:0] shifted;
  logic                carry_out;
  logic [CW-1:0]       cnt_inc;

  always_comb begin
    shifted   = {dig_q, mag_q} << 1;
    carry_out = dig_q[DW-1];
    cnt_inc   = cnt_q + CNT_ONE;
  end

  // ---------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (init) state_d = S_ADJ;
      S_ADJ:   state_d = S_SHIFT;
      S_SHIFT: state_d = (cnt_inc < CNT_LAST) ? S_ADJ : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Working datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    mag_d = mag_q;
    dig_d = dig_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    neg_d = neg_q;
    case (state_q)
      S_IDLE: begin
        if (init) begin
          mag_d = in_mag;
          dig_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          neg_d = in_neg;
        end
      end
      S_ADJ: begin
        dig_d = dig_adj;
      end
      S_SHIFT: begin
        {dig_d, mag_d} = shifted;
        cnt_d          = cnt_inc;
        ovf_d          = ovf_q | carry_out;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM process 3: output logic (feeds output registers, so every output
  // is a flop and no input reaches an output combinationally)
  // ---------------------------------------------------------------------
  always_comb begin
    busy_d = (state_d == S_ADJ) || (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
    bcd_d  = bcd_q;
    oneg_d = oneg_q;
    oovf_d = oovf_q;
    // Results are published only on the edge entering DONE, using the
    // post-shift working values, so intermediate digits are never visible.
    if ((state_q == S_SHIFT) && (state_d == S_DONE)) begin
      bcd_d  = dig_d;
      oneg_d = neg_q;
      oovf_d = ovf_d;
    end
  end

  // ---------------------------------------------------------------------
  // Working and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q  <= '0;
      dig_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      neg_q  <= 1'b0;
      bcd_q  <= '0;
      oneg_q <= 1'b0;
      oovf_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      mag_q  <= mag_d;
      dig_q  <= dig_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      neg_q  <= neg_d;
      bcd_q  <= bcd_d;
      oneg_q <= oneg_d;
      oovf_q <= oovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign out_BCD  = bcd_q;
  assign out_NEG  = oneg_q;
  assign out_OVF  = oovf_q;
  assign out_BUSY = busy_q;
  assign out_DONE = done_q;

endmodule

// File: tb/tb_bin2bcd_dd.sv
module tb_bin2bcd_dd;

  logic clk;
  logic rst;

  // Default instance: W_BIN=9, N_DIG=3
  logic        init0, sgn0;
  logic [8:0]  bin0;
  logic [11:0] bcd0;
  logic        neg0, ovf0, busy0, done0;

  // W_BIN=9, N_DIG=2
  logic        init2, sgn2;
  logic [8:0]  bin2;
  logic [7:0]  bcd2;
  logic        neg2, ovf2, busy2, done2;

  // W_BIN=16, N_DIG=5
  logic        init16, sgn16;
  logic [15:0] bin16;
  logic [19:0] bcd16;
  logic        neg16, ovf16, busy16, done16;

  int n_chk  = 0;
  int n_fail = 0;

  logic [39:0] r_bcd;
  logic        r_neg, r_ovf;

  bin2bcd_dd #(.W_BIN(9), .N_DIG(3)) u0 (
    .clk(clk), .rst(rst), .init(init0), .in_SIGNED(sgn0), .in_BIN(bin0),
    .out_BCD(bcd0), .out_NEG(neg0), .out_OVF(ovf0), .out_BUSY(busy0), .out_DONE(done0)
  );

  bin2bcd_dd #(.W_BIN(9), .N_DIG(2)) u2 (
    .clk(clk), .rst(rst), .init(init2), .in_SIGNED(sgn2), .in_BIN(bin2),
    .out_BCD(bcd2), .out_NEG(neg2), .out_OVF(ovf2), .out_BUSY(busy2), .out_DONE(done2)
  );

  bin2bcd_dd #(.W_BIN(16), .N_DIG(5)) u16 (
    .clk(clk), .rst(rst), .init(init16), .in_SIGNED(sgn16), .in_BIN(bin16),
    .out_BCD(bcd16), .out_NEG(neg16), .out_OVF(ovf16), .out_BUSY(busy16), .out_DONE(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion on instance 'which' (0: u0, 1: u2, 2: u16). Checks latency,
  // busy length and single-cycle done; leaves the results in r_bcd/r_neg/r_ovf.
  // With 'toggle', init and in_BIN on u0 are wiggled while the conversion runs.
  task automatic run(input int which, input logic s, input logic [31:0] b,
                     input int exp_lat, input bit toggle, input string tag);
    int   lat;
    int   nbusy;
    logic d;
    logic bz;
    lat   = -1;
    nbusy = 0;
    @(negedge clk);
    case (which)
      0:       begin sgn0  = s; bin0  = b[8:0];  init0  = 1'b1; end
      1:       begin sgn2  = s; bin2  = b[8:0];  init2  = 1'b1; end
      default: begin sgn16 = s; bin16 = b[15:0]; init16 = 1'b1; end
    endcase
    @(negedge clk);  // accepting edge has passed
    init0 = 1'b0; init2 = 1'b0; init16 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      case (which)
        0:       begin d = done0;  bz = busy0;  end
        1:       begin d = done2;  bz = busy2;  end
        default: begin d = done16; bz = busy16; end
      endcase
      if (d) begin
        lat = k;
        case (which)
          0:       begin r_bcd = 40'(bcd0);  r_neg = neg0;  r_ovf = ovf0;  end
          1:       begin r_bcd = 40'(bcd2);  r_neg = neg2;  r_ovf = ovf2;  end
          default: begin r_bcd = 40'(bcd16); r_neg = neg16; r_ovf = ovf16; end
        endcase
        break;
      end
      if (bz) nbusy++;
      if (toggle && which == 0) begin
        init0 = k[0];
        bin0  = 9'(300 + k);
      end
      @(negedge clk);
    end
    init0 = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy cycles"}, 64'(nbusy), 64'(exp_lat));
    @(negedge clk);
    case (which)
      0:       d = done0;
      1:       d = done2;
      default: d = done16;
    endcase
    chk({tag, " single pulse"}, 64'(d), 64'd0);
  endtask

  int          np;
  int          pc [4];
  logic [11:0] pb [4];
  logic        seen;

  initial begin
    rst = 1'b1;
    init0 = 1'b0; sgn0 = 1'b0; bin0 = '0;
    init2 = 1'b0; sgn2 = 1'b0; bin2 = '0;
    init16 = 1'b0; sgn16 = 1'b0; bin16 = '0;
    for (int i = 0; i < 4; i++) begin pc[i] = 0; pb[i] = '0; end

    // Reset state, before any clock edge
    #3;
    chk("reset bcd",  64'(bcd0),  64'h0);
    chk("reset neg",  64'(neg0),  64'h0);
    chk("reset ovf",  64'(ovf0),  64'h0);
    chk("reset busy", 64'(busy0), 64'h0);
    chk("reset done", 64'(done0), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Unsigned full scale
    run(0, 1'b0, 32'd511, 18, 1'b0, "u511");
    chk("u511 bcd", r_bcd, 40'h511);
    chk("u511 neg", 64'(r_neg), 64'h0);
    chk("u511 ovf", 64'(r_ovf), 64'h0);

    // Signed -1 and most negative value
    run(0, 1'b1, 32'h1FF, 18, 1'b0, "s-1");
    chk("s-1 bcd", r_bcd, 40'h001);
    chk("s-1 neg", 64'(r_neg), 64'h1);
    run(0, 1'b1, 32'h100, 18, 1'b0, "s-256");
    chk("s-256 bcd", r_bcd, 40'h256);
    chk("s-256 neg", 64'(r_neg), 64'h1);

    // Same pattern unsigned is positive 256
    run(0, 1'b0, 32'h100, 18, 1'b0, "u256");
    chk("u256 bcd", r_bcd, 40'h256);
    chk("u256 neg", 64'(r_neg), 64'h0);

    // Signed positive value (MSB clear)
    run(0, 1'b1, 32'h0FF, 18, 1'b0, "s255");
    chk("s255 bcd", r_bcd, 40'h255);
    chk("s255 neg", 64'(r_neg), 64'h0);

    // Signed zero
    run(0, 1'b1, 32'h0, 18, 1'b0, "s0");
    chk("s0 bcd", r_bcd, 40'h0);
    chk("s0 neg", 64'(r_neg), 64'h0);
    chk("s0 ovf", 64'(r_ovf), 64'h0);

    // Two-digit instance: overflow boundary
    run(1, 1'b0, 32'd100, 18, 1'b0, "n2 100");
    chk("n2 100 ovf", 64'(r_ovf), 64'h1);
    chk("n2 100 bcd", r_bcd, 40'h00);
    run(1, 1'b0, 32'd99, 18, 1'b0, "n2 99");
    chk("n2 99 ovf", 64'(r_ovf), 64'h0);
    chk("n2 99 bcd", r_bcd, 40'h99);
    run(1, 1'b0, 32'd511, 18, 1'b0, "n2 511");
    chk("n2 511 ovf", 64'(r_ovf), 64'h1);
    chk("n2 511 bcd", r_bcd, 40'h11);

    // 16-bit instance
    run(2, 1'b0, 32'hFFFF, 32, 1'b0, "w16 65535");
    chk("w16 65535 bcd", r_bcd, 40'h65535);
    chk("w16 65535 ovf", 64'(r_ovf), 64'h0);
    run(2, 1'b1, 32'h8000, 32, 1'b0, "w16 -32768");
    chk("w16 -32768 bcd", r_bcd, 40'h32768);
    chk("w16 -32768 neg", 64'(r_neg), 64'h1);

    // init held high with in_BIN changing every cycle: only IDLE-cycle values
    // are taken (100, 120, 140), done pulses 20 cycles apart.
    repeat (2) @(negedge clk);
    init0 = 1'b1; sgn0 = 1'b0; np = 0;
    for (int c = 0; c < 60; c++) begin
      bin0 = 9'(100 + c);
      @(negedge clk);
      if (done0) begin
        if (np < 4) begin pc[np] = c; pb[np] = bcd0; end
        np++;
      end
    end
    init0 = 1'b0;
    chk("held pulses", 64'(np), 64'd3);
    chk("held pulse0 cycle", 64'(pc[0]), 64'd18);
    chk("held pulse1 cycle", 64'(pc[1]), 64'd38);
    chk("held pulse2 cycle", 64'(pc[2]), 64'd58);
    chk("held pulse0 bcd", 64'(pb[0]), 64'h100);
    chk("held pulse1 bcd", 64'(pb[1]), 64'h120);
    chk("held pulse2 bcd", 64'(pb[2]), 64'h140);

    // init toggled while busy is ignored
    run(0, 1'b0, 32'd77, 18, 1'b1, "toggle");
    chk("toggle bcd", r_bcd, 40'h077);

    // Reset in the middle of a conversion of 255
    @(negedge clk);
    init0 = 1'b1; sgn0 = 1'b0; bin0 = 9'd255;
    @(negedge clk);
    init0 = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst bcd",  64'(bcd0),  64'h0);
    chk("midrst busy", 64'(busy0), 64'h0);
    chk("midrst done", 64'(done0), 64'h0);
    chk("midrst neg",  64'(neg0),  64'h0);
    chk("midrst ovf",  64'(ovf0),  64'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done0 || busy0) seen = 1'b1;
    end
    chk("midrst no activity", 64'(seen), 64'h0);
    run(0, 1'b0, 32'd42, 18, 1'b0, "after rst");
    chk("after rst bcd", r_bcd, 40'h042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
